fifo: RTL and testbench

// - Single-clock synchronous FIFO buffer between a producer and a consumer in the same clock domain.
// - Stores up to DEPTH words of DATA_WIDTH bits in first-in/first-out order.
// - Exposes a registered read-data output and full/empty status flags.
// - Intended as a general-purpose elastic buffer inside datapaths.

---
 rtl/fifo.sv | 68 ++++++
 tb/tb_fifo.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fifo
//  Description : Single-clock synchronous FIFO with registered read data and
//                count-derived full/empty flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty
);

  localparam int               c_ADDR_W   = $clog2(DEPTH);
  localparam logic [c_ADDR_W:0] c_FULL_CNT = (c_ADDR_W + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [c_ADDR_W-1:0]   r_wr_ptr;
  logic [c_ADDR_W-1:0]   r_rd_ptr;
  logic [c_ADDR_W:0]     r_count;
  logic                  w_rd_acc;
  logic                  w_wr_acc;

  assign full  = (r_count == c_FULL_CNT);
  assign empty = (r_count == '0);

  // A read in the same cycle frees a slot, so a write is accepted even when full.
  assign w_rd_acc = rd_en & ~empty;
  assign w_wr_acc = wr_en & (~full | w_rd_acc);

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      data_out <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + c_ADDR_W'(1);
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + c_ADDR_W'(1);
        data_out <= r_mem[r_rd_ptr];
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + (c_ADDR_W + 1)'(1);
        2'b01:   r_count <= r_count - (c_ADDR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo
//  Description : Scoreboard bench for fifo against a queue reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo;

  localparam int DEPTH      = 8;
  localparam int DATA_WIDTH = 8;

  logic                  clk;
  logic                  rst;
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  full;
  logic                  empty;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_WIDTH-1:0] model_q [$];
  logic [DATA_WIDTH-1:0] exp_q   [$];
  logic [DATA_WIDTH-1:0] last_out;

  fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .data_in  (data_in),
    .data_out (data_out),
    .full     (full),
    .empty    (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: consumes expected read words and checks outputs against the model.
  always @(negedge clk) begin
    if (!rst) begin
      last_out = '0;
      check("rst_data_out", 32'(data_out), 32'h0);
      check("rst_empty", 32'(empty), 32'h1);
      check("rst_full", 32'(full), 32'h0);
    end else begin
      if (exp_q.size() > 0) last_out = exp_q.pop_front();
      check("data_out", 32'(data_out), 32'(last_out));
      check("empty", 32'(empty), 32'(model_q.size() == 0));
      check("full", 32'(full), 32'(model_q.size() == DEPTH));
    end
  end

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic do_cycle(input logic w, input logic r, input logic [DATA_WIDTH-1:0] d);
    bit rd_acc;
    bit wr_acc;
    wr_en   = w;
    rd_en   = r;
    data_in = d;
    rd_acc  = r && (model_q.size() > 0);
    wr_acc  = w && ((model_q.size() < DEPTH) || rd_acc);
    @(posedge clk);
    if (rd_acc) exp_q.push_back(model_q.pop_front());
    if (wr_acc) model_q.push_back(d);
    @(negedge clk);
  endtask

  initial begin
    logic [DATA_WIDTH-1:0] v;
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
    #10;
    check("init_empty", 32'(empty), 32'h1);
    check("init_full", 32'(full), 32'h0);
    check("init_data_out", 32'(data_out), 32'h0);
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);

    // Fill, overflow attempt, drain, read past empty
    for (int i = 1; i <= 8; i++) do_cycle(1'b1, 1'b0, 8'(i));
    do_cycle(1'b1, 1'b0, 8'hFF);
    for (int i = 0; i < 8; i++) do_cycle(1'b0, 1'b1, 8'h00);
    do_cycle(1'b0, 1'b1, 8'h00);
    do_cycle(1'b0, 1'b0, 8'h00);

    // Wrap with simultaneous read/write at occupancy 1
    for (int i = 0; i < 3; i++) do_cycle(1'b1, 1'b0, 8'h10 + 8'(i));
    for (int i = 0; i < 2; i++) do_cycle(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 10; i++) do_cycle(1'b1, 1'b1, 8'h20 + 8'(i));

    // Simultaneous read/write while full
    for (int i = 0; i < 7; i++) do_cycle(1'b1, 1'b0, 8'h40 + 8'(i));
    for (int i = 0; i < 3; i++) do_cycle(1'b1, 1'b1, 8'h50 + 8'(i));
    for (int i = 0; i < 8; i++) do_cycle(1'b0, 1'b1, 8'h00);

    // Simultaneous read/write while empty: write only, no bypass
    do_cycle(1'b1, 1'b1, 8'h66);
    do_cycle(1'b0, 1'b1, 8'h00);
    do_cycle(1'b0, 1'b0, 8'h00);

    // Asynchronous reset with four words stored
    for (int i = 0; i < 4; i++) do_cycle(1'b1, 1'b0, 8'h70 + 8'(i));
    wr_en = 1'b0; rd_en = 1'b0;
    #2 rst = 1'b0;
    model_q.delete();
    exp_q.delete();
    #1;
    check("async_rst_empty", 32'(empty), 32'h1);
    check("async_rst_full", 32'(full), 32'h0);
    check("async_rst_data_out", 32'(data_out), 32'h0);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    do_cycle(1'b1, 1'b0, 8'hA5);
    do_cycle(1'b1, 1'b0, 8'h5A);
    do_cycle(1'b0, 1'b1, 8'h00);
    do_cycle(1'b0, 1'b1, 8'h00);
    do_cycle(1'b0, 1'b0, 8'h00);

    // Randomized traffic with phases biased toward filling and draining
    for (int i = 0; i < 600; i++) begin
      int wp;
      wp = ((i / 100) % 2 == 0) ? 75 : 30;
      v  = 8'($urandom);
      do_cycle(1'($urandom_range(99) < wp), 1'($urandom_range(99) < 55), v);
    end
    for (int i = 0; i < DEPTH + 1; i++) do_cycle(1'b0, 1'b1, 8'h00);
    do_cycle(1'b0, 1'b0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
